// File: rtl/led_chaser_n_if.sv
// Signal bundle between the LED chaser and whatever drives its switches/enable.
// The master supplies sw/en and observes the pattern, accepted mode and step pulse.
interface led_chaser_n_if #(
    parameter int N_LED = 8
);
    logic [1:0]       sw;
    logic             en;
    logic [N_LED-1:0] led;
    logic [1:0]       mode;
    logic             step;

    modport master (
        output sw,
        output en,
        input  led,
        input  mode,
        input  step
    );

    modport slave (
        input  sw,
        input  en,
        output led,
        output mode,
        output step
    );
endinterface

// File: rtl/led_chaser_n.sv
// LED chaser with synchronized, debounced mode switches, a step prescaler and four
// patterns (fill-left, fill-right, bounce, blink); a mode change restarts the pattern.
module led_chaser_n #(
    parameter int N_LED = 8,
    parameter int DIV   = 4,
    parameter int DEB   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    led_chaser_n_if.slave  bus
);

    localparam int              PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(DIV - 1);
    localparam logic [7:0]      DEB_CNT = 8'(DEB);

    typedef enum logic [1:0] {
        FILL_L = 2'd0,
        FILL_R = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       sw_last_q, sw_last_d;
    logic [7:0]       deb_cnt_q, deb_cnt_d;
    mode_e            mode_q, mode_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             phase_q, phase_d;
    logic             step_q, step_d;

    logic             mode_load;
    logic [7:0]       run_len;
    logic             pre_wrap;
    logic [N_LED-1:0] shifted;

    function automatic logic [N_LED-1:0] start_state(input mode_e m);
        logic [N_LED-1:0] s;
        case (m)
            BOUNCE:  s = N_LED'(1);
            BLINK:   s = '1;
            default: s = '0;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_last_q <= '0;
            deb_cnt_q <= '0;
            mode_q    <= FILL_L;
            pre_q     <= '0;
            led_q     <= '0;
            phase_q   <= 1'b1;
            step_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sw_last_q <= sw_last_d;
            deb_cnt_q <= deb_cnt_d;
            mode_q    <= mode_d;
            pre_q     <= pre_d;
            led_q     <= led_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
        end
    end

    // run_len counts the current cycle, so DEB stable cycles after the synchronizer
    // load the mode on the DEB-th edge, giving 2+DEB cycles from a clean switch change.
    always_comb begin
        sync1_d   = bus.sw;
        sync2_d   = sync1_q;
        sw_last_d = sync2_q;
        mode_d    = mode_q;
        deb_cnt_d = deb_cnt_q;
        mode_load = 1'b0;
        run_len   = (sync2_q != sw_last_q) ? 8'd1 : deb_cnt_q + 8'd1;
        if (sync2_q == mode_q) begin
            deb_cnt_d = '0;
        end else if (run_len == DEB_CNT) begin
            mode_load = 1'b1;
            mode_d    = mode_e'(sync2_q);
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = run_len;
        end
    end

    always_comb begin
        pre_wrap = bus.en && (pre_q == PRE_MAX);
        pre_d    = pre_q;
        led_d    = led_q;
        phase_d  = phase_q;
        step_d   = 1'b0;
        shifted  = '0;
        if (mode_load) begin
            led_d   = start_state(mode_d);
            phase_d = 1'b1;
            pre_d   = '0;
        end else if (bus.en) begin
            pre_d = pre_wrap ? '0 : pre_q + PW'(1);
            if (pre_wrap) begin
                step_d = 1'b1;
                // phase_q means "inserting ones" for the fills and "moving up" for bounce.
                case (mode_q)
                    FILL_L: begin
                        shifted = {led_q[N_LED-2:0], phase_q};
                        led_d   = shifted;
                        if (phase_q && (&shifted))
                            phase_d = 1'b0;
                        else if (!phase_q && (shifted == '0))
                            phase_d = 1'b1;
                    end
                    FILL_R: begin
                        shifted = {phase_q, led_q[N_LED-1:1]};
                        led_d   = shifted;
                        if (phase_q && (&shifted))
                            phase_d = 1'b0;
                        else if (!phase_q && (shifted == '0))
                            phase_d = 1'b1;
                    end
                    BOUNCE: begin
                        if (phase_q) begin
                            shifted = led_q << 1;
                            phase_d = !shifted[N_LED-1];
                        end else begin
                            shifted = led_q >> 1;
                            phase_d = shifted[0];
                        end
                        led_d = shifted;
                    end
                    BLINK: begin
                        led_d = ~led_q;
                    end
                    default: begin
                        led_d = led_q;
                    end
                endcase
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.mode = mode_q;
    assign bus.step = step_q;

endmodule

// File: doc/led_chaser_n.md
LED_CHASER_N -- requirements
Module: led_chaser_n

Interface
REQ-001 Parameter N_LED, default 8: number of LED outputs; legal range 4..32.
REQ-002 Parameter DIV, default 4: clock cycles per pattern step; legal range 1..2^24.
REQ-003 Parameter DEB, default 3: consecutive stable cycles required to accept a new mode; legal range 1..255.
REQ-004 The block SHALL have the port clk, input, width 1, the single clock; all flops SHALL be rising-edge.
REQ-005 The block SHALL have the port rst_n, input, width 1, reset; it SHALL be asynchronous and active-low.
REQ-006 The block SHALL have the port sw, input, width 2, raw mode switches, asynchronous to clk.
REQ-007 The block SHALL have the port en, input, width 1; high = run, low = freeze.
REQ-008 The block SHALL have the port led, output, width N_LED, pattern; registered.
REQ-009 The block SHALL have the port mode, output, width 2, accepted mode; registered.
REQ-010 The block SHALL have the port step, output, width 1, one-cycle pulse on each pattern update; registered.

Function
REQ-011 sw SHALL pass through a 2-flop synchronizer; sw_s denotes the second-stage output.
REQ-012 Debounce: a counter SHALL clear whenever sw_s changes or sw_s == mode. When sw_s != mode has held stable for DEB consecutive cycles, mode SHALL load sw_s. Total latency from a clean sw change to mode update SHALL be 2+DEB cycles.
REQ-013 Prescaler: it SHALL count 0..DIV-1 while en=1. On the count of DIV-1 it SHALL wrap to 0 and assert step for that cycle. With DIV=1, step SHALL be high every enabled cycle.
REQ-014 The pattern (led) SHALL update only in cycles where step=1.
REQ-015 Mode 0, FILL_L: start state all-zeros. Each step SHALL shift left, inserting 1 at bit0 until all ones, then inserting 0 until all zeros, then repeat. The period SHALL be 2*N_LED steps.
REQ-016 Mode 1, FILL_R: this mode SHALL be the mirror of mode 0. It SHALL shift right, inserting at bit N_LED-1, from a start state of all-zeros, with a period of 2*N_LED steps.
REQ-017 Mode 2, BOUNCE: exactly one LED SHALL be lit. Start state is bit0 with direction up. The lit LED SHALL move one position per step. Direction SHALL reverse on reaching bit N_LED-1 or bit0, with no repeated endpoint. The period SHALL be 2*N_LED-2 steps.
REQ-018 Mode 3, BLINK: start state all-ones; led SHALL invert every step.
REQ-019 On a mode update, in the same edge: led SHALL load the new mode's start state, the prescaler SHALL clear to 0, the fill/bounce phase SHALL reset, and step SHALL be 0.
REQ-020 en=0: prescaler, led, and phase SHALL hold and step SHALL be 0; synchronizer and debounce SHALL keep running, so a mode change is still accepted and applies its start state while frozen.
REQ-021 A mode change and step in the same cycle: the mode update SHALL take priority; led SHALL equal the new start state.
REQ-022 sw toggling faster than DEB cycles SHALL never change mode.
REQ-023 The internal phase/direction state SHALL be sized for N_LED up to 32 with no overflow at wrap.

Reset
REQ-024 While rst_n=0: led=0, mode=0, step=0, prescaler=0, debounce count=0, synchronizer flops=0, FILL phase=insert-ones.
REQ-025 Reset assertion mid-pattern SHALL clear state immediately, without waiting for clk. After deassertion, the first step SHALL occur DIV enabled cycles later.
REQ-026 After reset, if sw != 0, mode SHALL update after 2+DEB cycles per REQ-012.

Verification
REQ-027 The bench SHALL cover: N_LED=8, DIV=4, sw=0, en=1 from reset -> step every 4th cycle; led = 01,03,07,...,FF,FE,FC,...,00 and repeating every 16 steps.
REQ-028 The bench SHALL cover: sw 0->2 held -> mode=2 exactly 5 cycles after the change; led=01; then 02,04,...,80,40,...,01 with period 14 steps.
REQ-029 The bench SHALL cover: sw glitch 0->3 for 2 cycles then back to 0 -> mode stays 0; led sequence is undisturbed.
REQ-030 The bench SHALL cover: mode 3 running, en=0 for 20 cycles -> led and step are frozen; en=1 -> next step occurs after the remaining prescaler count, and led inverts.
REQ-031 The bench SHALL cover: rst_n pulsed low mid-sequence in mode 1 (led=E0) -> led=00 and mode=0 asynchronously; after release with sw=1 -> mode=1 after 5 cycles, then led=80,C0,... .
REQ-032 The bench SHALL cover: N_LED=4, DIV=1 in mode 2 -> led=1,2,4,8,4,2,1 on consecutive cycles; step is held continuously high.
